// File: rtl/morse_keyer_fifo.sv
// Buffered Morse keyer: a character FIFO feeding a unit-timed key/lamp FSM.
// Define MORSE_WORD_GAP_EN to accept code 36 as a 4-unit word space.
module morse_keyer_fifo #(
    parameter int UNIT_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [5:0]                  num,
    input  logic                        ready,
    output logic                        full,
    output logic                        key,
    output logic                        ponto,
    output logic                        traco,
    output logic                        busy,
    output logic                        err,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
`ifdef MORSE_WORD_GAP_EN
    localparam logic [5:0] MAX_CODE = 6'd36;
`else
    localparam logic [5:0] MAX_CODE = 6'd35;
`endif

    typedef logic [AW:0] lvl_t;
    typedef enum logic [2:0] {IDLE, MARK, SPACE, CGAP, WGAP} state_t;

    // {len, pattern} with the first symbol in pattern bit 4, 1 = dash
    function automatic logic [7:0] lookup(input logic [5:0] c);
        logic [7:0] r;
        case (c)
            6'd0:  r = {3'd5, 5'b11111};
            6'd1:  r = {3'd5, 5'b01111};
            6'd2:  r = {3'd5, 5'b00111};
            6'd3:  r = {3'd5, 5'b00011};
            6'd4:  r = {3'd5, 5'b00001};
            6'd5:  r = {3'd5, 5'b00000};
            6'd6:  r = {3'd5, 5'b10000};
            6'd7:  r = {3'd5, 5'b11000};
            6'd8:  r = {3'd5, 5'b11100};
            6'd9:  r = {3'd5, 5'b11110};
            6'd10: r = {3'd2, 5'b01000};
            6'd11: r = {3'd4, 5'b10000};
            6'd12: r = {3'd4, 5'b10100};
            6'd13: r = {3'd3, 5'b10000};
            6'd14: r = {3'd1, 5'b00000};
            6'd15: r = {3'd4, 5'b00100};
            6'd16: r = {3'd3, 5'b11000};
            6'd17: r = {3'd4, 5'b00000};
            6'd18: r = {3'd2, 5'b00000};
            6'd19: r = {3'd4, 5'b01110};
            6'd20: r = {3'd3, 5'b10100};
            6'd21: r = {3'd4, 5'b01000};
            6'd22: r = {3'd2, 5'b11000};
            6'd23: r = {3'd2, 5'b10000};
            6'd24: r = {3'd3, 5'b11100};
            6'd25: r = {3'd4, 5'b01100};
            6'd26: r = {3'd4, 5'b11010};
            6'd27: r = {3'd3, 5'b01000};
            6'd28: r = {3'd3, 5'b00000};
            6'd29: r = {3'd1, 5'b10000};
            6'd30: r = {3'd3, 5'b00100};
            6'd31: r = {3'd4, 5'b00010};
            6'd32: r = {3'd3, 5'b01100};
            6'd33: r = {3'd4, 5'b10010};
            6'd34: r = {3'd4, 5'b10110};
            6'd35: r = {3'd4, 5'b11000};
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    state_t        state, state_n;
    logic [4:0]    sh, sh_n;
    logic [2:0]    rem, rem_n;
    logic [CW-1:0] ucyc;
    logic [1:0]    units, dur_m1;
    logic          tick, done, take;
    lvl_t          wp, rp, cnt_n;
    logic [5:0]    mem [FIFO_DEPTH];
    logic [5:0]    head;
    logic [7:0]    code_lut;
    logic          wr_try, push, pop, bad, nonempty;
    logic          key_n, ponto_n, traco_n, busy_n;

    assign wr_try   = ready && !full;
    assign push     = wr_try && (num <= MAX_CODE);
    assign bad      = wr_try && (num > MAX_CODE);
    assign nonempty = (level != '0);
    assign head     = mem[rp[AW-1:0]];
    assign code_lut = lookup(head);
    assign pop      = take;
    assign cnt_n    = level + lvl_t'(push) - lvl_t'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            full  <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (push) wp <= wp + lvl_t'(1);
            if (pop)  rp <= rp + lvl_t'(1);
            level <= cnt_n;
            full  <= (cnt_n == lvl_t'(FIFO_DEPTH));
            err   <= bad;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= num;
    end

    assign tick = (ucyc == CW'(UNIT_CYCLES - 1));
    assign done = tick && (units == dur_m1);

    always_comb begin
        dur_m1 = 2'd0;
        unique case (state)
            MARK:    dur_m1 = sh[4] ? 2'd2 : 2'd0;
            CGAP:    dur_m1 = 2'd2;
            WGAP:    dur_m1 = 2'd3;
            default: dur_m1 = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sh    <= '0;
            rem   <= '0;
            ucyc  <= '0;
            units <= '0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            rem   <= rem_n;
            if (state == IDLE || done) begin
                ucyc  <= '0;
                units <= '0;
            end else if (tick) begin
                ucyc  <= '0;
                units <= units + 2'd1;
            end else begin
                ucyc <= ucyc + CW'(1);
            end
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        rem_n   = rem;
        take    = 1'b0;
        unique case (state)
            IDLE: take = nonempty;
            MARK: begin
                if (done) state_n = (rem == 3'd1) ? CGAP : SPACE;
            end
            SPACE: begin
                if (done) begin
                    state_n = MARK;
                    sh_n    = {sh[3:0], 1'b0};
                    rem_n   = rem - 3'd1;
                end
            end
            CGAP, WGAP: begin
                if (done) begin
                    take = nonempty;
                    if (!nonempty) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (take) begin
            state_n = MARK;
            sh_n    = code_lut[4:0];
            rem_n   = code_lut[7:5];
`ifdef MORSE_WORD_GAP_EN
            if (head == 6'd36) state_n = WGAP;
`endif
        end
    end

    // Outputs are registered from the next state so they align with it
    always_comb begin
        key_n   = (state_n == MARK);
        ponto_n = key_n && !sh_n[4];
        traco_n = key_n && sh_n[4];
        busy_n  = (state_n != IDLE) || (cnt_n != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key   <= 1'b0;
            ponto <= 1'b0;
            traco <= 1'b0;
            busy  <= 1'b0;
        end else begin
            key   <= key_n;
            ponto <= ponto_n;
            traco <= traco_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_morse_keyer_fifo.sv
// Scoreboard bench for morse_keyer_fifo: expected marks/gaps queued
// from a Morse string table, checked by a key-waveform monitor.
module tb_morse_keyer_fifo;
    localparam int U = 2;
`ifdef MORSE_WORD_GAP_EN
    localparam int MAXC = 36;
`else
    localparam int MAXC = 35;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] num;
    logic       ready;
    logic       full, key, ponto, traco, busy, err;
    logic [2:0] level;

    morse_keyer_fifo #(.UNIT_CYCLES(U), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .num(num), .ready(ready),
        .full(full), .key(key), .ponto(ponto), .traco(traco),
        .busy(busy), .err(err), .level(level)
    );

    always #5 clk = ~clk;

    string morse_tab [0:35] = '{
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
        "-.--", "--.."
    };

    // gap < 0: at least 3 units of silence; otherwise exact cycles
    typedef struct {bit dash; int gap;} exp_t;
    exp_t exp_q[$];
    int   next_gap;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic push_char(input int code);
        exp_t e;
        string s;
        if (code == 36) begin
            next_gap = 7 * U;
        end else begin
            s = morse_tab[code];
            for (int i = 0; i < s.len(); i++) begin
                e.dash = (s.getc(i) == "-");
                e.gap  = (i == 0) ? next_gap : U;
                exp_q.push_back(e);
            end
            next_gap = 3 * U;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int code);
        num   = 6'(code);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        if (code <= MAXC) begin
            push_char(code);
            check("err_quiet", err, 0);
        end else begin
            check("err_pulse", err, 1);
        end
    endtask

    task automatic wait_not_full();
        for (int i = 0; i < 200; i++) begin
            if (!full) break;
            step(1);
        end
        check("full_clears", full, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000; i++) begin
            if (!busy && !key) break;
            step(1);
        end
        step(2);
        check("drain_busy", busy, 0);
        check("drain_level", level, 0);
        check("drain_full", full, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    // Monitor: measures each mark and the silence before it
    bit   in_mark = 0;
    bit   cur_ok  = 0;
    exp_t cur;
    int   run = 0, gap = 1000, lamp_bad = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_mark = 0;
            gap     = 1000;
        end else if (key) begin
            if (!in_mark) begin
                check("mark_expected", exp_q.size() > 0, 1);
                cur_ok = (exp_q.size() > 0);
                if (cur_ok) begin
                    cur = exp_q.pop_front();
                    if (cur.gap < 0) check("gap_min", gap >= 3 * U, 1);
                    else check("gap_exact", gap, cur.gap);
                end
                in_mark  = 1;
                run      = 0;
                lamp_bad = 0;
            end
            run++;
            if (cur_ok && (ponto !== !cur.dash || traco !== cur.dash))
                lamp_bad++;
        end else begin
            check("lamp_off", {ponto, traco}, 0);
            if (in_mark) begin
                if (cur_ok) begin
                    check("mark_len", run, cur.dash ? 3 * U : U);
                    check("mark_lamp", lamp_bad, 0);
                end
                in_mark = 0;
                gap     = 0;
            end
            gap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int codes [6];
        reset_n = 1'b0;
        ready   = 1'b0;
        num     = '0;
        #3;
        check("rst_key", key, 0);
        check("rst_lamps", {ponto, traco}, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(2);

        // E: one dot, key high one cycle after the accept edge
        next_gap = -1;
        do_write(14);
        check("e_key_late", key, 0);
        check("e_level1", level, 1);
        check("e_busy", busy, 1);
        step(1);
        check("e_key_on", key, 1);
        check("e_ponto", ponto, 1);
        check("e_level0", level, 0);
        step(2);
        check("e_key_off", key, 0);
        step(5);
        check("e_busy_gap", busy, 1);
        step(1);
        check("e_busy_done", busy, 0);
        drain();

        // A, then Z+I back to back
        next_gap = -1;
        do_write(10);
        drain();
        next_gap = -1;
        do_write(35);
        do_write(18);
        drain();

        // Six writes on consecutive cycles: five accepted
        codes    = '{14, 29, 18, 22, 5, 14};
        next_gap = -1;
        for (int i = 0; i < 6; i++) begin
            num   = 6'(codes[i]);
            ready = 1'b1;
            step(1);
            if (i < 5) push_char(codes[i]);
            check("burst_err", err, 0);
        end
        ready = 1'b0;
        check("burst_full", full, 1);
        check("burst_level", level, 4);
        drain();

        // Out-of-range code
        do_write(40);
        check("bad_level", level, 0);
        step(1);
        check("err_one_cycle", err, 0);

        // Reset in the middle of a dash
        next_gap = -1;
        do_write(0);
        do_write(5);
        for (int i = 0; i < 40; i++) begin
            if (traco) break;
            step(1);
        end
        check("dash_seen", traco, 1);
        step(1);
        reset_n = 1'b0;
        #1;
        check("abort_key", key, 0);
        check("abort_traco", traco, 0);
        check("abort_level", level, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        check("abort_idle", busy, 0);

`ifdef MORSE_WORD_GAP_EN
        next_gap = -1;
        do_write(14);
        do_write(36);
        do_write(14);
        drain();
`endif

        // Random bursts, occasionally salted with invalid codes
        for (int b = 0; b < 10; b++) begin
            int n;
            n        = $urandom_range(1, 6);
            next_gap = -1;
            for (int k = 0; k < n; k++) begin
                wait_not_full();
                if ($urandom_range(0, 7) == 0)
                    do_write($urandom_range(MAXC + 1, 63));
                step($urandom_range(0, 2));
                wait_not_full();
                do_write($urandom_range(0, 35));
            end
            drain();
            step($urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
